// File: rtl/button_debounce_pulse_pkg.sv
// Shared reaction-timer definitions: debounce FSM encodings, board debounce
// constant and the registered output bundle.
package button_debounce_pulse_pkg;

  // 10 ms at the 100 MHz board clock.
  localparam int BOARD_DB_CYCLES = 1000000;

  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_ONE   = 2'd2;
  localparam logic [1:0] ST_WAIT0 = 2'd3;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } db_out_t;

  // Debounced level is high in ONE and WAIT0, which both have the top bit set.
  function automatic logic st_level(input logic [1:0] st);
    return st[1];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; only o_q may be used
// downstream.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// Pushbutton debouncer: synchronizes the raw level, accepts a change only
// after DB_CYCLES stable cycles, and emits one-cycle press/release pulses.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int DB_CYCLES = BOARD_DB_CYCLES,
  parameter int CNT_W     = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  db_out_t          out_q, out_nxt;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_btn),
    .o_q     (sync)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = '0;
    case (state)
      ST_ZERO: if (sync) begin
        state_nxt = ST_WAIT1;
        cnt_nxt   = '0;
      end
      ST_WAIT1: begin
        if (!sync) begin
          state_nxt = ST_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = ST_ONE;
          out_nxt.press = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_ONE: if (!sync) begin
        state_nxt = ST_WAIT0;
        cnt_nxt   = '0;
      end
      ST_WAIT0: begin
        if (sync) begin
          state_nxt = ST_ONE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_ZERO;
          out_nxt.rel = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_ZERO;
        cnt_nxt   = '0;
      end
    endcase
    // Level is registered from the next state so it rises with o_press.
    out_nxt.level = st_level(state_nxt);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_ZERO;
      cnt   <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out_q <= out_nxt;
    end
  end

  assign o_level   = out_q.level;
  assign o_press   = out_q.press;
  assign o_release = out_q.rel;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse with DB_CYCLES=4: expected pulse
// events are queued when the button is driven and checked cycle by cycle.
module tb_button_debounce_pulse;

  typedef struct {
    int at;
    bit is_press;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic level, press, rel;

  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  logic exp_level = 1'b0;
  ev_t  q[$];

  button_debounce_pulse #(.DB_CYCLES(4), .CNT_W(4)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_btn     (btn),
    .o_level   (level),
    .o_press   (press),
    .o_release (rel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @edge %0d: got %0b want %0b", tag, edge_n, obs, exp);
    end
  endtask

  // Button edge k is the next posedge; a change held from k is accepted after k+6.
  task automatic expect_ev(input bit is_press);
    ev_t e;
    e.at = edge_n + 7;
    e.is_press = is_press;
    q.push_back(e);
  endtask

  task automatic tick();
    logic ep, er;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    ep = 1'b0;
    er = 1'b0;
    if (q.size() > 0 && q[0].at == edge_n) begin
      ev_t e;
      e = q.pop_front();
      if (e.is_press) begin ep = 1'b1; exp_level = 1'b1; end
      else begin er = 1'b1; exp_level = 1'b0; end
    end
    chk("press", press, ep);
    chk("release", rel, er);
    chk("level", level, exp_level);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; btn = 1'b0;
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // Held press: single pulse, then nothing for 50 cycles
    btn = 1'b1; expect_ev(1'b1);
    ticks(56);
    btn = 1'b0; expect_ev(1'b0);
    ticks(10);

    // Short 3-cycle blip is rejected
    btn = 1'b1; ticks(3);
    btn = 1'b0; ticks(12);

    // Debounced high, then bouncing every 2 cycles, then settle low
    btn = 1'b1; expect_ev(1'b1);
    ticks(10);
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    btn = 1'b0; expect_ev(1'b0);
    ticks(12);

    // Reset mid-WAIT1 (counter=2) with the button held
    btn = 1'b1;
    ticks(5);
    q.delete(); exp_level = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0; expect_ev(1'b1);
    ticks(10);
    btn = 1'b0; expect_ev(1'b0);
    ticks(10);

    // Reset mid-WAIT0 must not emit a late release
    btn = 1'b1; expect_ev(1'b1);
    ticks(10);
    btn = 1'b0;
    ticks(4);
    q.delete(); exp_level = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    ticks(10);

    // Three full press/release cycles
    for (int r = 0; r < 3; r++) begin
      btn = 1'b1; expect_ev(1'b1);
      ticks(10);
      btn = 1'b0; expect_ev(1'b0);
      ticks(10);
    end

    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL pending_events: got %0d want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
